// File: rtl/mvau_seq_ctrl.sv
// Input-reuse sequencer for the MVAU datapath: buffers one SF-word vector and replays it NF times.
// Optional performance counters are enabled by defining MVAU_SEQ_PERF_EN.
module mvau_seq_ctrl #(
  parameter int SF           = 4,
  parameter int NF           = 2,
  parameter int TI           = 8,
  parameter int WMEM_ADDR_BW = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TI-1:0]           in,
  input  logic                    in_v,
  output logic                    in_rdy,
  output logic [TI-1:0]           out_act,
  output logic                    out_v,
  input  logic                    out_rdy,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic                    out_last,
`ifdef MVAU_SEQ_PERF_EN
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_vec_cnt,
`endif
  output logic                    vec_done
);

  localparam int SF_W = (SF > 1) ? $clog2(SF) : 1;
  localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [SF_W-1:0]         SF_LAST   = SF_W'(SF - 1);
  localparam logic [NF_W-1:0]         NF_LAST   = NF_W'(NF - 1);
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(SF * NF - 1);

  localparam logic [0:0] FILL   = 1'b0;
  localparam logic [0:0] REPLAY = 1'b1;

  logic [0:0]              state_r;
  logic [SF_W-1:0]         sf_cnt_r;
  logic [NF_W-1:0]         nf_cnt_r;
  logic [TI-1:0]           buf_r [SF];
  logic                    adv_s;
  logic                    in_xfer_s;
  logic                    sf_last_s;
  logic                    nf_last_s;
  logic [WMEM_ADDR_BW-1:0] addr_s;

  // Handshake and address decode; nf_cnt is zero in FILL so one formula serves both states.
  always_comb begin
    adv_s     = !out_v || out_rdy;
    in_rdy    = (state_r == FILL) && adv_s;
    in_xfer_s = in_v && in_rdy;
    sf_last_s = (sf_cnt_r == SF_LAST);
    nf_last_s = (nf_cnt_r == NF_LAST);
    addr_s    = WMEM_ADDR_BW'(nf_cnt_r) * WMEM_ADDR_BW'(SF) + WMEM_ADDR_BW'(sf_cnt_r);
  end

  // Vector buffer, written only while filling; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_xfer_s) begin
      buf_r[sf_cnt_r] <= in;
    end else begin
      buf_r[sf_cnt_r] <= buf_r[sf_cnt_r];
    end
  end

  // Sequencer state, counters and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= FILL;
      sf_cnt_r  <= '0;
      nf_cnt_r  <= '0;
      out_act   <= '0;
      out_v     <= 1'b0;
      wmem_addr <= '0;
      out_last  <= 1'b0;
      vec_done  <= 1'b0;
    end else begin
      vec_done <= out_v && out_rdy && (wmem_addr == LAST_ADDR);
      if (adv_s) begin
        case (state_r)
          FILL: begin
            if (in_xfer_s) begin
              out_act   <= in;
              out_v     <= 1'b1;
              wmem_addr <= addr_s;
              out_last  <= sf_last_s;
              if (sf_last_s) begin
                sf_cnt_r <= '0;
                if (NF == 1) begin
                  state_r <= FILL;
                end else begin
                  nf_cnt_r <= NF_W'(1);
                  state_r  <= REPLAY;
                end
              end else begin
                sf_cnt_r <= sf_cnt_r + SF_W'(1);
              end
            end else begin
              out_v <= 1'b0;
            end
          end
          REPLAY: begin
            out_act   <= buf_r[sf_cnt_r];
            out_v     <= 1'b1;
            wmem_addr <= addr_s;
            out_last  <= sf_last_s;
            if (sf_last_s) begin
              sf_cnt_r <= '0;
              if (nf_last_s) begin
                nf_cnt_r <= '0;
                state_r  <= FILL;
              end else begin
                nf_cnt_r <= nf_cnt_r + NF_W'(1);
              end
            end else begin
              sf_cnt_r <= sf_cnt_r + SF_W'(1);
            end
          end
          default: begin
            state_r  <= FILL;
            sf_cnt_r <= '0;
            nf_cnt_r <= '0;
            out_v    <= 1'b0;
          end
        endcase
      end else begin
        out_v <= out_v;
      end
    end
  end

`ifdef MVAU_SEQ_PERF_EN
  // Saturating stall-cycle and completed-vector counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'd0;
      perf_vec_cnt   <= 32'd0;
    end else begin
      if (out_v && !out_rdy && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
      if (vec_done && (perf_vec_cnt != 32'hFFFF_FFFF)) begin
        perf_vec_cnt <= perf_vec_cnt + 32'd1;
      end else begin
        perf_vec_cnt <= perf_vec_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mvau_seq_ctrl.sv
// Directed bench for mvau_seq_ctrl: SF=4/NF=2 main instance plus an SF=1/NF=1 instance.
module tb_mvau_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in;
  logic       in_v;
  logic       in_rdy;
  logic [7:0] out_act;
  logic       out_v;
  logic       out_rdy;
  logic [2:0] wmem_addr;
  logic       out_last;
  logic       vec_done;

  logic [7:0] in1;
  logic       in_v1;
  logic       in_rdy1;
  logic [7:0] out_act1;
  logic       out_v1;
  logic       out_rdy1;
  logic [0:0] wmem_addr1;
  logic       out_last1;
  logic       vec_done1;

`ifdef MVAU_SEQ_PERF_EN
  logic [31:0] perf_stall_cnt, perf_vec_cnt, perf_stall_cnt1, perf_vec_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mvau_seq_ctrl #(.SF(4), .NF(2), .TI(8), .WMEM_ADDR_BW(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_v(in_v), .in_rdy(in_rdy),
    .out_act(out_act), .out_v(out_v), .out_rdy(out_rdy), .wmem_addr(wmem_addr),
    .out_last(out_last),
`ifdef MVAU_SEQ_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_vec_cnt(perf_vec_cnt),
`endif
    .vec_done(vec_done)
  );

  mvau_seq_ctrl #(.SF(1), .NF(1), .TI(8), .WMEM_ADDR_BW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .in_v(in_v1), .in_rdy(in_rdy1),
    .out_act(out_act1), .out_v(out_v1), .out_rdy(out_rdy1), .wmem_addr(wmem_addr1),
    .out_last(out_last1),
`ifdef MVAU_SEQ_PERF_EN
    .perf_stall_cnt(perf_stall_cnt1), .perf_vec_cnt(perf_vec_cnt1),
`endif
    .vec_done(vec_done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] act, input int addr, input logic last);
    chk({tag, "_v"}, 32'(out_v), 32'd1);
    chk({tag, "_act"}, 32'(out_act), 32'(act));
    chk({tag, "_addr"}, 32'(wmem_addr), 32'(addr));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
  endtask

  logic [7:0] va  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] vb  [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
  logic [7:0] vc  [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
  logic [7:0] vab [2][4] = '{'{8'h51, 8'h52, 8'h53, 8'h54}, '{8'h61, 8'h62, 8'h63, 8'h64}};
  logic [7:0] vd  [4] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};

  initial begin
    rst_n = 1'b0; in = 8'h00; in_v = 1'b0; out_rdy = 1'b1;
    in1 = 8'h00; in_v1 = 1'b0; out_rdy1 = 1'b1;
    tick(); tick();
    chk("rst_v", 32'(out_v), 32'd0);
    chk("rst_act", 32'(out_act), 32'd0);
    chk("rst_addr", 32'(wmem_addr), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(vec_done), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_v1", 32'(out_v1), 32'd0);
    rst_n = 1'b1;

    // streaming with out_rdy held high
    for (int k = 0; k < 4; k++) begin
      in = va[k]; in_v = 1'b1;
      chk("t1_in_rdy_fill", 32'(in_rdy), 32'd1);
      tick();
      chk_out("t1_fill", va[k], k, k == 3);
    end
    in_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_in_rdy_replay", 32'(in_rdy), 32'd0);
      tick();
      chk_out("t1_replay", va[k], 4 + k, k == 3);
    end
    chk("t1_done_early", 32'(vec_done), 32'd0);
    tick();
    chk("t1_bubble", 32'(out_v), 32'd0);
    chk("t1_done", 32'(vec_done), 32'd1);
    tick();
    chk("t1_done_clr", 32'(vec_done), 32'd0);

    // downstream stall while address 5 is presented
    for (int k = 0; k < 4; k++) begin
      in = vb[k]; in_v = 1'b1;
      tick();
    end
    in_v = 1'b0;
    tick();
    tick();
    chk_out("t2_pre", vb[1], 5, 1'b0);
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("t2_stall", vb[1], 5, 1'b0);
      chk("t2_in_rdy", 32'(in_rdy), 32'd0);
    end
    out_rdy = 1'b1;
    tick();
    chk_out("t2_a6", vb[2], 6, 1'b0);
    tick();
    chk_out("t2_a7", vb[3], 7, 1'b1);
    tick();
    chk("t2_done", 32'(vec_done), 32'd1);
    tick();
`ifdef MVAU_SEQ_PERF_EN
    chk("t2_perf_stall", perf_stall_cnt, 32'd3);
    chk("t2_perf_vec", perf_vec_cnt, 32'd2);
`endif

    // upstream gaps produce bubbles in FILL only
    for (int k = 0; k < 4; k++) begin
      in = vc[k]; in_v = 1'b1;
      tick();
      chk_out("t3_fill", vc[k], k, k == 3);
      in_v = 1'b0;
      if (k < 3) begin
        tick();
        chk("t3_gap", 32'(out_v), 32'd0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out("t3_replay", vc[k], 4 + k, k == 3);
    end
    tick();
    chk("t3_done", 32'(vec_done), 32'd1);

    // two back-to-back vectors with no idle cycle
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 4; k++) begin
        in = vab[v][k]; in_v = 1'b1;
        tick();
        chk_out("t4_fill", vab[v][k], k, k == 3);
        if (v == 1 && k == 0) chk("t4_done_a", 32'(vec_done), 32'd1);
      end
      in_v = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk_out("t4_replay", vab[v][k], 4 + k, k == 3);
      end
    end
    tick();
    chk("t4_done_b", 32'(vec_done), 32'd1);
    tick();

    // reset in the middle of replay
    for (int k = 0; k < 4; k++) begin
      in = vd[k]; in_v = 1'b1;
      tick();
    end
    in_v = 1'b0;
    tick();
    tick();
    chk_out("t5_pre", vd[1], 5, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_v", 32'(out_v), 32'd0);
    chk("t5_rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("t5_rst_addr", 32'(wmem_addr), 32'd0);
`ifdef MVAU_SEQ_PERF_EN
    chk("t5_perf_stall", perf_stall_cnt, 32'd0);
    chk("t5_perf_vec", perf_vec_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    in = 8'hE5; in_v = 1'b1;
    tick();
    chk_out("t5_restart", 8'hE5, 0, 1'b0);
    in = 8'hE6;
    tick();
    chk_out("t5_restart2", 8'hE6, 1, 1'b0);
    in_v = 1'b0;

    // SF=1, NF=1 instance
    in1 = 8'h5A; in_v1 = 1'b1;
    chk("t6_in_rdy", 32'(in_rdy1), 32'd1);
    tick();
    chk("t6_v0", 32'(out_v1), 32'd1);
    chk("t6_act0", 32'(out_act1), 32'h5A);
    chk("t6_addr0", 32'(wmem_addr1), 32'd0);
    chk("t6_last0", 32'(out_last1), 32'd1);
    chk("t6_done0", 32'(vec_done1), 32'd0);
    in1 = 8'h6B;
    tick();
    chk("t6_act1", 32'(out_act1), 32'h6B);
    chk("t6_last1", 32'(out_last1), 32'd1);
    chk("t6_done1", 32'(vec_done1), 32'd1);
    in_v1 = 1'b0;
    tick();
    chk("t6_v2", 32'(out_v1), 32'd0);
    chk("t6_done2", 32'(vec_done1), 32'd1);
    tick();
    chk("t6_done3", 32'(vec_done1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
